// File: rtl/load_interlock_pkg.sv
// Shared types for the load-use interlock: FSM state encodings and register constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package load_interlock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RELEASE = 2'd2,
    USE     = 2'd3
  } li_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  // True when the ID instruction really reads register rs and it equals rd.
  function automatic logic src_hit(input logic uses, input logic [4:0] rs, input logic [4:0] rd);
    return uses && (rs == rd);
  endfunction

endpackage

// File: rtl/load_interlock_if.sv
// Bundle of pipeline-control, EX-field and dmem-response signals seen by the interlock.
// Latency: n/a (wiring only).
// Backpressure: stall_if_id/bubble_ex are the backpressure toward IF/ID and EX.
interface load_interlock_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic [4:0]  ex_rd;
  logic        ex_valid;
  logic        ex_load_en;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        stall_if_id;
  logic        bubble_ex;
  logic        ex_rs1_ldfwd;
  logic        ex_rs2_ldfwd;
  logic [31:0] load_fwd_value;
  logic        load_pending;

  // Pipeline side: supplies instruction fields and dmem response, consumes control.
  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_valid, ex_load_en,
           mem_resp_valid, mem_resp_data,
    input  stall_if_id, bubble_ex, ex_rs1_ldfwd, ex_rs2_ldfwd, load_fwd_value, load_pending
  );

  // Interlock side.
  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_valid, ex_load_en,
           mem_resp_valid, mem_resp_data,
    output stall_if_id, bubble_ex, ex_rs1_ldfwd, ex_rs2_ldfwd, load_fwd_value, load_pending
  );
endinterface

// File: rtl/load_interlock.sv
// Load-use interlock: stalls IF/ID and bubbles EX until load data returns, then forwards it.
// Latency: N-th WAIT-cycle response costs N+1 stall cycles; forward value is registered.
// Backpressure: stall_if_id/bubble_ex combinational from state and ID/EX fields.
// Optional: LOAD_WAIT_TIMEOUT_EN adds a saturating WAIT counter and sticky timeout_err.
module load_interlock
  import load_interlock_pkg::*;
`ifdef LOAD_WAIT_TIMEOUT_EN
#(
  parameter int MAX_WAIT = 15
)
`endif
(
  input  logic               clk,
  input  logic               rst,
  load_interlock_if.slave    lif
`ifdef LOAD_WAIT_TIMEOUT_EN
  ,
  output logic               timeout_err
`endif
);

  li_state_e   state_q, state_d;
  logic        m1_q, m1_d;
  logic        m2_q, m2_d;
  logic [31:0] fwd_q, fwd_d;
  logic        hit1, hit2, hazard;
  logic        stall, bubble, rs1_fwd, rs2_fwd;

  assign hit1   = src_hit(lif.id_uses_rs1, lif.id_rs1, lif.ex_rd);
  assign hit2   = src_hit(lif.id_uses_rs2, lif.id_rs2, lif.ex_rd);
  assign hazard = lif.ex_valid && lif.ex_load_en && (lif.ex_rd != REG_X0) && (hit1 || hit2);

  // Next-state and control outputs; USE re-checks the hazard so chained loads re-enter WAIT.
  always_comb begin
    state_d = state_q;
    m1_d    = m1_q;
    m2_d    = m2_q;
    fwd_d   = fwd_q;
    stall   = 1'b0;
    bubble  = 1'b0;
    rs1_fwd = 1'b0;
    rs2_fwd = 1'b0;
    case (state_q)
      IDLE: begin
        if (hazard) begin
          stall   = 1'b1;
          bubble  = 1'b1;
          m1_d    = hit1;
          m2_d    = hit2;
          state_d = WAIT;
        end
      end
      WAIT: begin
        stall  = 1'b1;
        bubble = 1'b1;
        if (lif.mem_resp_valid) begin
          fwd_d   = lif.mem_resp_data;
          state_d = RELEASE;
        end
      end
      RELEASE: state_d = USE;
      USE: begin
        rs1_fwd = m1_q;
        rs2_fwd = m2_q;
        if (hazard) begin
          stall   = 1'b1;
          bubble  = 1'b1;
          m1_d    = hit1;
          m2_d    = hit2;
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand-match flags and captured load data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m1_q    <= 1'b0;
      m2_q    <= 1'b0;
      fwd_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      m1_q    <= m1_d;
      m2_q    <= m2_d;
      fwd_q   <= fwd_d;
    end
  end

  assign lif.stall_if_id    = stall;
  assign lif.bubble_ex      = bubble;
  assign lif.ex_rs1_ldfwd   = rs1_fwd;
  assign lif.ex_rs2_ldfwd   = rs2_fwd;
  assign lif.load_fwd_value = fwd_q;
  assign lif.load_pending   = (state_q == WAIT);

`ifdef LOAD_WAIT_TIMEOUT_EN
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

  logic [CW-1:0] cnt_q;
  logic          terr_q;
  logic          enter_wait;

  assign enter_wait = (state_d == WAIT) && (state_q != WAIT);

  // Count unanswered WAIT cycles; flag is sticky once the limit is hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      terr_q <= 1'b0;
    end else if (enter_wait) begin
      cnt_q <= '0;
    end else if ((state_q == WAIT) && !lif.mem_resp_valid && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q + 1'b1 == CNT_MAX) terr_q <= 1'b1;
    end
  end

  assign timeout_err = terr_q;
`endif

endmodule

// File: tb/tb_load_interlock.sv
// Directed bench for load_interlock with a per-cycle expectation scoreboard.
// Latency: expectations are pushed when a cycle's stimulus is applied, popped at negedge.
// Backpressure: n/a.
module tb_load_interlock;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  load_interlock_if lif();
`ifdef LOAD_WAIT_TIMEOUT_EN
  logic terr;
`endif

  load_interlock dut (
    .clk (clk),
    .rst (rst),
    .lif (lif)
`ifdef LOAD_WAIT_TIMEOUT_EN
    ,
    .timeout_err (terr)
`endif
  );

  always #5 clk = ~clk;

  // {stall, bubble, rs1_ldfwd, rs2_ldfwd, load_pending}
  logic [4:0]  exp_ctl_q[$];
  logic [31:0] exp_val_q[$];
  string       exp_tag_q[$];

  // Monitor: compare outputs against the oldest pending expectation.
  always @(negedge clk) begin
    if (exp_ctl_q.size() != 0) begin
      logic [4:0]  e_ctl, g_ctl;
      logic [31:0] e_val;
      string       tag;
      e_ctl = exp_ctl_q.pop_front();
      e_val = exp_val_q.pop_front();
      tag   = exp_tag_q.pop_front();
      g_ctl = {lif.stall_if_id, lif.bubble_ex, lif.ex_rs1_ldfwd, lif.ex_rs2_ldfwd, lif.load_pending};
      checks++;
      if (g_ctl !== e_ctl || lif.load_fwd_value !== e_val) begin
        errors++;
        $display("FAIL %s: got ctl=%b val=%h, expected ctl=%b val=%h", tag, g_ctl,
                 lif.load_fwd_value, e_ctl, e_val);
      end
    end
  end

  // One cycle: drive inputs, queue the expected outputs for this cycle, advance past the edge.
  task automatic cyc(input string tag, input logic r,
                     input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                     input logic [4:0] exrd, input logic exv, input logic exl,
                     input logic rv, input logic [31:0] rdat,
                     input logic [4:0] e_ctl, input logic [31:0] e_val);
    rst                = r;
    lif.id_rs1         = rs1;
    lif.id_uses_rs1    = u1;
    lif.id_rs2         = rs2;
    lif.id_uses_rs2    = u2;
    lif.ex_rd          = exrd;
    lif.ex_valid       = exv;
    lif.ex_load_en     = exl;
    lif.mem_resp_valid = rv;
    lif.mem_resp_data  = rdat;
    exp_ctl_q.push_back(e_ctl);
    exp_val_q.push_back(e_val);
    exp_tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

`ifdef LOAD_WAIT_TIMEOUT_EN
  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", tag, got, exp);
    end
  endtask
`endif

  initial begin
    lif.id_rs1 = '0; lif.id_rs2 = '0; lif.id_uses_rs1 = 1'b0; lif.id_uses_rs2 = 1'b0;
    lif.ex_rd = '0; lif.ex_valid = 1'b0; lif.ex_load_en = 1'b0;
    lif.mem_resp_valid = 1'b0; lif.mem_resp_data = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    //   tag               r  rs1 u1 rs2 u2 exrd v ld rv data          ctl       val
    cyc("reset",          0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        5'b00000, 32'h0);
    // lw x5 ; add x6,x5,x7 with single-cycle response
    cyc("t1_detect",      0, 5, 1, 7, 1, 5, 1, 1, 0, 32'h0,        5'b11000, 32'h0);
    cyc("t1_wait",        0, 5, 1, 7, 1, 0, 0, 0, 1, 32'hDEADBEEF, 5'b11001, 32'h0);
    cyc("t1_release",     0, 5, 1, 7, 1, 0, 0, 0, 0, 32'h0,        5'b00000, 32'hDEADBEEF);
    cyc("t1_use",         0, 1, 1, 2, 1, 6, 1, 0, 0, 32'h0,        5'b00100, 32'hDEADBEEF);
    cyc("t1_idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        5'b00000, 32'hDEADBEEF);
    // no-hazard cases; response outside WAIT is ignored
    cyc("x0_load",        0, 0, 1, 0, 1, 0, 1, 1, 0, 32'h0,        5'b00000, 32'hDEADBEEF);
    cyc("resp_in_idle",   0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h11111111, 5'b00000, 32'hDEADBEEF);
    cyc("resp_ignored",   0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        5'b00000, 32'hDEADBEEF);
    cyc("src_not_used",   0, 4, 0, 4, 0, 4, 1, 1, 0, 32'h0,        5'b00000, 32'hDEADBEEF);
    cyc("ex_bubble",      0, 4, 1, 0, 0, 4, 0, 1, 0, 32'h0,        5'b00000, 32'hDEADBEEF);
    cyc("ex_not_load",    0, 4, 1, 0, 0, 4, 1, 0, 0, 32'h0,        5'b00000, 32'hDEADBEEF);
    // load x3, response in the 4th WAIT cycle, consumer reads x3 on both sources
    cyc("t3_detect",      0, 3, 1, 3, 1, 3, 1, 1, 0, 32'h0,        5'b11000, 32'hDEADBEEF);
    cyc("t3_wait1",       0, 3, 1, 3, 1, 0, 0, 0, 0, 32'h12345678, 5'b11001, 32'hDEADBEEF);
    cyc("t3_wait2",       0, 3, 1, 3, 1, 0, 0, 0, 0, 32'h12345678, 5'b11001, 32'hDEADBEEF);
    cyc("t3_wait3",       0, 3, 1, 3, 1, 0, 0, 0, 0, 32'h12345678, 5'b11001, 32'hDEADBEEF);
    cyc("t3_wait4",       0, 3, 1, 3, 1, 0, 0, 0, 1, 32'h000000A5, 5'b11001, 32'hDEADBEEF);
    cyc("t3_release",     0, 3, 1, 3, 1, 0, 0, 0, 0, 32'h0,        5'b00000, 32'h000000A5);
    cyc("t3_use",         0, 0, 0, 0, 0, 8, 1, 0, 0, 32'h0,        5'b00110, 32'h000000A5);
    cyc("t3_idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        5'b00000, 32'h000000A5);
    // lw x1 ; lw x2,0(x1) ; add x3,x2,x0
    cyc("t4_detect1",     0, 1, 1, 0, 0, 1, 1, 1, 0, 32'h0,        5'b11000, 32'h000000A5);
    cyc("t4_wait1",       0, 1, 1, 0, 0, 0, 0, 0, 1, 32'h00000100, 5'b11001, 32'h000000A5);
    cyc("t4_release1",    0, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0,        5'b00000, 32'h00000100);
    cyc("t4_use1_detect2",0, 2, 1, 0, 1, 2, 1, 1, 0, 32'h0,        5'b11100, 32'h00000100);
    cyc("t4_wait2",       0, 2, 1, 0, 1, 0, 0, 0, 1, 32'h00002222, 5'b11001, 32'h00000100);
    cyc("t4_release2",    0, 2, 1, 0, 1, 0, 0, 0, 0, 32'h0,        5'b00000, 32'h00002222);
    cyc("t4_use2",        0, 0, 0, 0, 0, 3, 1, 0, 0, 32'h0,        5'b00100, 32'h00002222);
    cyc("t4_idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        5'b00000, 32'h00002222);
    // reset in the second WAIT cycle abandons the load
    cyc("t5_detect",      0, 9, 0, 9, 1, 9, 1, 1, 0, 32'h0,        5'b11000, 32'h00002222);
    cyc("t5_wait1",       0, 9, 0, 9, 1, 0, 0, 0, 0, 32'h0,        5'b11001, 32'h00002222);
    cyc("t5_wait2_rst",   1, 9, 0, 9, 1, 0, 0, 0, 0, 32'h0,        5'b11001, 32'h00002222);
    cyc("t5_after_rst",   0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h00005555, 5'b00000, 32'h0);
    cyc("t5_resp_ignored",0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        5'b00000, 32'h0);

`ifdef LOAD_WAIT_TIMEOUT_EN
    chk1("terr_clear", terr, 1'b0);
    cyc("to_detect",      0, 7, 1, 0, 0, 7, 1, 1, 0, 32'h0,        5'b11000, 32'h0);
    for (int i = 0; i < 14; i++)
      cyc("to_wait",      0, 7, 1, 0, 0, 0, 0, 0, 0, 32'h0,        5'b11001, 32'h0);
    chk1("terr_at_14", terr, 1'b0);
    cyc("to_wait15",      0, 7, 1, 0, 0, 0, 0, 0, 0, 32'h0,        5'b11001, 32'h0);
    chk1("terr_at_15", terr, 1'b1);
    cyc("to_resp",        0, 7, 1, 0, 0, 0, 0, 0, 1, 32'h00000077, 5'b11001, 32'h0);
    cyc("to_release",     0, 7, 1, 0, 0, 0, 0, 0, 0, 32'h0,        5'b00000, 32'h00000077);
    cyc("to_use",         0, 0, 0, 0, 0, 4, 1, 0, 0, 32'h0,        5'b00100, 32'h00000077);
    chk1("terr_sticky", terr, 1'b1);
    cyc("to_rst",         1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        5'b00000, 32'h00000077);
    chk1("terr_after_rst", terr, 1'b0);
`endif

    for (int i = 0; i < 10 && exp_ctl_q.size() != 0; i++) @(negedge clk);
    if (exp_ctl_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_ctl_q.size());
    end
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
